// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: shared definitions for the UART register-bus master.
//   - command/response byte codes exchanged with the host
//   - FSM state type of uart_bus_master
//   - ADDR byte field positions (mirrored by the host software header)
package uart_bus_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  // ADDR byte layout: [7:4] decoder leg index, [3:0] register offset
  localparam int unsigned LEG_MSB = 7;
  localparam int unsigned LEG_LSB = 4;
  localparam int unsigned OFS_MSB = 3;
  localparam int unsigned OFS_LSB = 0;

  // Register data always travels as four bytes, LSB first
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [2:0] byte_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_SEND
  } bus_state_t;

endpackage

// File: rtl/uart_bus_tx_serializer.sv
// uart_bus_tx_serializer: emits 1..4 bytes of a word, LSB first, over a
// valid/ready handshake toward the UART transmitter.
//   clk, rst     clock, asynchronous active-high reset
//   load         capture load_word/load_count (only while idle)
//   load_word    word to send, byte 0 goes out first
//   load_count   number of bytes to send (1 or 4)
//   tx_data      current byte, stable while tx_valid && !tx_ready
//   tx_valid     a byte is on offer
//   tx_ready     transmitter accepts on tx_valid && tx_ready
//   done         pulses in the cycle the last byte is accepted
module uart_bus_tx_serializer
  import uart_bus_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  byte_cnt_t             load_count,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  logic [WORD_WIDTH-1:0] word_q;
  byte_cnt_t             left_q;
  logic                  accept;

  assign accept   = tx_valid && tx_ready;
  assign tx_valid = (left_q != '0);
  assign tx_data  = word_q[7:0];
  assign done     = accept && (left_q == byte_cnt_t'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      left_q <= '0;
    end else if (load) begin
      word_q <= load_word;
      left_q <= load_count;
    end else if (accept) begin
      word_q <= word_q >> 8;
      left_q <= left_q - byte_cnt_t'(1);
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: sole initiator on the register-file bus. Parses command
// frames received from the UART, issues single-cycle read/write strobes and
// returns read data / acknowledgements to the UART transmitter.
//   clk, rst          clock, asynchronous active-high reset
//   rx_data/rx_valid  received byte, rx_valid is a one-cycle pulse
//   tx_data/tx_valid/tx_ready  response byte stream (valid/ready)
//   addr              register offset (holds last value)
//   wr_en, rd_en      one-cycle write / read strobes
//   wdata             write data (holds last value)
//   addr_decoder_leg  one-hot block select, nonzero only with a strobe
//   rdata             combinational read data, sampled in the rd_en cycle
//   busy              FSM not in IDLE
//   timeout_err       pulse after an inter-byte timeout aborted a frame
//   rx_drop           pulse after a byte was discarded in BUS_*/SEND
// Frame: CMD ('W'/'R'), ADDR ([7:4] leg, [3:0] offset), write adds 4 data
// bytes LSB first. Responses: 'K' for write, 4 data bytes for read, 'E' on
// bad command or out-of-range leg.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_LEGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [NUM_LEGS-1:0]   addr_decoder_leg,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  rx_drop
);

  localparam int unsigned LEG_W = (NUM_LEGS > 1) ? $clog2(NUM_LEGS) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  bus_state_t state_q, state_d;

  logic                  is_wr_q;
  logic [1:0]            byte_q;
  logic [LEG_W-1:0]      leg_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic                  timeout_q;
  logic                  drop_q;

  logic                  ser_load;
  logic [DATA_WIDTH-1:0] ser_word;
  byte_cnt_t             ser_count;
  logic                  ser_done;

  logic in_get;
  logic cmd_ok;
  logic leg_bad;
  logic to_hit;
  logic to_fire;
  logic latch_addr;
  logic take_data;
  logic drop;

  assign in_get  = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign cmd_ok  = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign leg_bad = 32'(rx_data[LEG_MSB:LEG_LSB]) >= NUM_LEGS;
  assign to_hit  = in_get && (to_cnt_q == TO_MAX);

  assign busy        = (state_q != ST_IDLE);
  assign wr_en       = (state_q == ST_BUS_WR);
  assign rd_en       = (state_q == ST_BUS_RD);
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign timeout_err = timeout_q;
  assign rx_drop     = drop_q;

  always_comb begin
    addr_decoder_leg = '0;
    if ((state_q == ST_BUS_WR) || (state_q == ST_BUS_RD)) begin
      addr_decoder_leg[leg_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A byte arriving in the cycle the timeout would fire takes priority:
  // the rx_valid branches are tested before to_hit.
  always_comb begin
    state_d    = state_q;
    ser_load   = 1'b0;
    ser_word   = '0;
    ser_count  = byte_cnt_t'(1);
    latch_addr = 1'b0;
    take_data  = 1'b0;
    to_fire    = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (cmd_ok) begin
            state_d = ST_GET_ADDR;
          end else begin
            ser_load = 1'b1;
            ser_word = DATA_WIDTH'(RSP_ERR);
            state_d  = ST_SEND;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rx_valid) begin
          if (leg_bad) begin
            ser_load = 1'b1;
            ser_word = DATA_WIDTH'(RSP_ERR);
            state_d  = ST_SEND;
          end else begin
            latch_addr = 1'b1;
            state_d    = is_wr_q ? ST_GET_DATA : ST_BUS_RD;
          end
        end else if (to_hit) begin
          to_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_valid) begin
          take_data = 1'b1;
          if (byte_q == 2'd3) begin
            state_d = ST_BUS_WR;
          end
        end else if (to_hit) begin
          to_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BUS_WR: begin
        drop     = rx_valid;
        ser_load = 1'b1;
        ser_word = DATA_WIDTH'(RSP_ACK);
        state_d  = ST_SEND;
      end
      ST_BUS_RD: begin
        drop      = rx_valid;
        ser_load  = 1'b1;
        ser_word  = rdata;
        ser_count = byte_cnt_t'(WORD_BYTES);
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        drop = rx_valid;
        if (ser_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr_q   <= 1'b0;
      byte_q    <= '0;
      leg_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && rx_valid) begin
        is_wr_q <= (rx_data == CMD_WRITE);
      end
      if (latch_addr) begin
        addr_q <= rx_data[ADDR_WIDTH-1:0];
        leg_q  <= LEG_W'(rx_data[LEG_MSB:LEG_LSB]);
        byte_q <= '0;
      end
      if (take_data) begin
        wdata_q[{byte_q, 3'b000} +: 8] <= rx_data;
        byte_q <= byte_q + 2'd1;
      end
      // Runs only while a frame is partially received; saturates at TO_MAX
      if (!in_get || rx_valid) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      timeout_q <= to_fire;
      drop_q    <= drop;
    end
  end

  uart_bus_tx_serializer #(
    .WORD_WIDTH (DATA_WIDTH)
  ) u_tx_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_word  (ser_word),
    .load_count (ser_count),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed self-checking bench for uart_bus_master
// (TIMEOUT_CYCLES = 20). Inputs change 2 time units after the rising edge;
// outputs are observed on the falling edge.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [3:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [3:0]  addr_decoder_leg;
  logic [31:0] rdata;
  logic        busy;
  logic        timeout_err;
  logic        rx_drop;

  always #5 clk = ~clk;

  uart_bus_master #(
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (32),
    .NUM_LEGS       (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .addr             (addr),
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .wdata            (wdata),
    .addr_decoder_leg (addr_decoder_leg),
    .rdata            (rdata),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .rx_drop          (rx_drop)
  );

  // Register file: leg 1, offset 'h4 holds 0x0010_0C08
  always_comb begin
    rdata = 32'h0;
    if (rd_en && (addr_decoder_leg == 4'b0010) && (addr == 4'h4)) rdata = 32'h0010_0C08;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: when stalling, holds tx_ready low for 5 offered cycles per byte
  logic stall_en = 1'b0;
  int   wait_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (!stall_en) begin
      tx_ready = 1'b1;
      wait_cnt = 0;
    end else if (tx_ready) begin
      tx_ready = 1'b0;
      wait_cnt = 0;
    end else if (tx_valid) begin
      wait_cnt++;
      if (wait_cnt >= 5) tx_ready = 1'b1;
    end
  end

  // Monitor (falling edge)
  int          cyc = 0, last_rx_cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0, tx_rise_cyc = 0;
  int          to_cnt = 0, to_cyc = 0, drop_cnt = 0, stray = 0;
  int          hold_seen = 0, hold_bad = 0;
  logic [3:0]  wr_addr = '0, rd_addr = '0, wr_leg = '0, rd_leg = '0;
  logic [31:0] wr_data = '0;
  logic [7:0]  txq[$];
  logic        prev_stall = 1'b0, prev_valid = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) last_rx_cyc = cyc;
    if (wr_en) begin
      wr_cnt++; wr_cyc = cyc; wr_addr = addr; wr_leg = addr_decoder_leg; wr_data = wdata;
    end
    if (rd_en) begin
      rd_cnt++; rd_cyc = cyc; rd_addr = addr; rd_leg = addr_decoder_leg;
    end
    if (!wr_en && !rd_en && (addr_decoder_leg != 4'b0)) stray++;
    if (tx_valid && !prev_valid) tx_rise_cyc = cyc;
    if (tx_valid && prev_stall) begin
      hold_seen++;
      if (tx_data != prev_data) hold_bad++;
    end
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (timeout_err) begin to_cnt++; to_cyc = cyc; end
    if (rx_drop) drop_cnt++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_valid = tx_valid;
  end

  int b_wr, b_rd, b_to, b_drop, b_tx, b_stray, b_hold_seen, b_hold_bad;

  task automatic mark();
    b_wr = wr_cnt; b_rd = rd_cnt; b_to = to_cnt; b_drop = drop_cnt;
    b_tx = txq.size(); b_stray = stray; b_hold_seen = hold_seen; b_hold_bad = hold_bad;
  endtask

  // Entered and left 2 units after a rising edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((busy || tx_valid) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy | tx_valid), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic check_tx(input string tag, input logic [31:0] word, input int nbytes);
    check({tag, "_txn"}, 64'(txq.size() - b_tx), 64'(nbytes));
    if (txq.size() - b_tx == nbytes) begin
      for (int i = 0; i < nbytes; i++) begin
        check({tag, "_txb"}, 64'(txq[b_tx + i]), 64'(word[8*i +: 8]));
      end
    end
  endtask

  task automatic check_write(input string tag, input logic [3:0] leg, input logic [3:0] a,
                             input logic [31:0] d);
    check({tag, "_wrn"}, 64'(wr_cnt - b_wr), 64'd1);
    check({tag, "_rdn"}, 64'(rd_cnt - b_rd), 64'd0);
    check({tag, "_leg"}, 64'(wr_leg), 64'(leg));
    check({tag, "_addr"}, 64'(wr_addr), 64'(a));
    check({tag, "_wdata"}, 64'(wr_data), 64'(d));
    check({tag, "_lat"}, 64'(wr_cyc - last_rx_cyc), 64'd1);
    check({tag, "_stray"}, 64'(stray - b_stray), 64'd0);
    check_tx(tag, 32'h4B, 1);
  endtask

  task automatic check_read(input string tag);
    check({tag, "_rdn"}, 64'(rd_cnt - b_rd), 64'd1);
    check({tag, "_wrn"}, 64'(wr_cnt - b_wr), 64'd0);
    check({tag, "_leg"}, 64'(rd_leg), 64'd2);
    check({tag, "_addr"}, 64'(rd_addr), 64'd4);
    check({tag, "_stray"}, 64'(stray - b_stray), 64'd0);
    check_tx(tag, 32'h0010_0C08, 4);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_wrn"}, 64'(wr_cnt - b_wr), 64'd0);
    check({tag, "_rdn"}, 64'(rd_cnt - b_rd), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check_tx(tag, 32'h45, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_leg", 64'(addr_decoder_leg), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_drop", 64'(rx_drop), 64'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // Write leg 0 offset 0
    mark();
    send_byte(8'h57); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h34); send_byte(8'h12);
    wait_idle("wr_idle");
    check_write("wr", 4'b0001, 4'h0, 32'h1234_5AA5);

    // Read leg 1 offset 4
    mark();
    send_byte(8'h52); send_byte(8'h14);
    wait_idle("rd_idle");
    check_read("rd");
    check("rd_lat", 64'(rd_cyc - last_rx_cyc), 64'd1);
    check("rd_tx_lat", 64'(tx_rise_cyc - rd_cyc), 64'd1);

    // Same read under transmitter backpressure
    stall_en = 1'b1;
    mark();
    send_byte(8'h52); send_byte(8'h14);
    wait_idle("bp_idle");
    check_read("bp");
    check("bp_hold_bad", 64'(hold_bad - b_hold_bad), 64'd0);
    check("bp_stalled", 64'((hold_seen - b_hold_seen) >= 12), 64'd1);
    stall_en = 1'b0;
    @(posedge clk); #2;

    // Invalid command
    mark();
    send_byte(8'h41);
    wait_idle("badcmd_idle");
    check_err("badcmd");

    // Leg index out of range (5, then exactly NUM_LEGS)
    mark();
    send_byte(8'h52); send_byte(8'h50);
    wait_idle("leg5_idle");
    check_err("leg5");
    mark();
    send_byte(8'h52); send_byte(8'h40);
    wait_idle("leg4_idle");
    check_err("leg4");

    // Timeout mid-frame, then a complete frame
    mark();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h11);
    repeat (25) @(posedge clk);
    #2;
    check("to_pulses", 64'(to_cnt - b_to), 64'd1);
    check("to_when", 64'(to_cyc - last_rx_cyc), 64'd21);
    check("to_wrn", 64'(wr_cnt - b_wr), 64'd0);
    check("to_txn", 64'(txq.size() - b_tx), 64'd0);
    check("to_busy", 64'(busy), 64'd0);
    mark();
    send_byte(8'h57); send_byte(8'h21);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_idle("after_to_idle");
    check_write("after_to", 4'b0100, 4'h1, 32'hDDCC_BBAA);

    // Byte arriving in the very cycle the timeout would fire wins
    mark();
    send_byte(8'h57);
    repeat (18) @(posedge clk);
    #2;
    send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle("race_idle");
    check("race_no_to", 64'(to_cnt - b_to), 64'd0);
    check_write("race", 4'b0001, 4'h0, 32'h0403_0201);

    // Overrun: byte during SEND is dropped
    stall_en = 1'b1;
    mark();
    send_byte(8'h52); send_byte(8'h14);
    send_byte(8'h52);
    wait_idle("ovr_idle");
    check("ovr_drop", 64'(drop_cnt - b_drop), 64'd1);
    check_read("ovr");

    // Reset mid-SEND
    mark();
    send_byte(8'h52); send_byte(8'h14);
    repeat (2) @(posedge clk);
    #2;
    check("mid_sending", 64'(tx_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_leg", 64'(addr_decoder_leg), 64'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    stall_en = 1'b0;
    @(posedge clk); #2;
    check("post_rst_busy", 64'(busy), 64'd0);
    mark();
    send_byte(8'h57); send_byte(8'h30);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_idle("post_rst_idle");
    check_write("post_rst", 4'b1000, 4'h0, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
